dm_store_buffer: RTL and testbench
==================================

Name: dm_store_buffer

Overview:
- Store buffer between the CPU datapath's store/load path and the word-addressed data memory (dm).
- Queues byte-enabled stores in a FIFO and drains them into dm one word per cycle using read-merge-write, relying on dm's combinational read port.
- Owns dm's single address port and arbitrates it between draining and CPU loads.
- Forwards pending buffered bytes into load results, so loads always see program-order data.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- AW, 12, dm word-address width; word address = byte address bits [AW+1:2].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clock clk.
- st_valid  in  1  CPU store request.
- st_ready  out  1  store accepted on this edge when st_valid && st_ready.
- st_addr  in  32  store byte address; bits [1:0] ignored.
- st_data  in  32  store data, already lane-aligned.
- st_be  in  4  byte enables; bit i covers data[8i+7:8i].
- st_pc  in  32  PC of the store, kept for trace.
- ld_valid  in  1  CPU load request (combinational).
- ld_addr  in  32  load byte address.
- ld_data  out  32  load result, dm word with buffered bytes forwarded in.
- ld_stall  out  1  load not serviced this cycle; CPU must hold.
- flush  in  1  drain request; blocks new stores while high.
- empty  out  1  count == 0.
- mem_we  out  1  dm write enable.
- mem_addr  out  AW  dm word address.
- mem_wdata  out  32  dm write data.
- mem_rdata  in  32  dm combinational read data at mem_addr.
- mem_pc  out  32  PC of the draining entry.
- mem_full_addr  out  32  full byte address of the draining entry, with bits [1:0] forced to 0.

Behaviour:
- Storage per entry: valid, full address, data, be, pc. Circular head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH. Count of width log2(DEPTH)+1.
- Reset (async): all valid bits, head, tail and count cleared.
  - Resulting outputs: st_ready=1, empty=1, mem_we=0, ld_stall=0.
  - mem_addr=0 when idle; ld_data follows mem_rdata.
- st_ready = (count < DEPTH) && !flush. A store accepted at a full-but-draining edge is not allowed; st_ready uses registered count only.
- Enqueue writes the entry at tail on the clk edge; tail and count increment.
- Port arbitration, combinational, per cycle:
  - ld_valid && count < DEPTH: load owns the port. mem_addr = ld_addr[AW+1:2], mem_we=0, ld_stall=0, no drain.
  - ld_valid && count == DEPTH: drain owns the port and ld_stall=1. This prevents deadlock.
  - !ld_valid && count > 0: drain owns the port.
  - Otherwise: idle, mem_we=0.
- Drain cycle:
  - mem_addr = head addr[AW+1:2], mem_we=1.
  - mem_wdata = per byte lane, be ? entry data : mem_rdata.
  - mem_pc = head pc; mem_full_addr = {head addr[31:2], 2'b00}.
  - dm commits on the same edge; head increments, count decrements, entry valid cleared.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- Load forwarding:
  - Base is mem_rdata.
  - Overlay, byte lane by byte lane, every valid entry with matching word address, oldest to youngest, so the youngest store wins per byte.
  - Zero-cycle latency.
  - A store presented in the same cycle is not yet buffered and is not forwarded. The CPU issues it before dependent loads.
- flush: st_ready forced 0. Draining proceeds under normal arbitration. CPU waits for empty=1.
- Reset mid-drain: pending entries are discarded. mem_we drops immediately because it is combinational from count.

Optional Feature:
- STORE_BUF_TRACE_EN defined: on each drain edge, print "@%h: *%h <= %h" with mem_pc, mem_full_addr, mem_wdata. This is simulation-only and guarded out of synthesis.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Test Plan:
- Reset, then store 0x12345678 be=4'hF to addr 0x10, no loads -> one cycle later mem_we=1, mem_addr=0x004, mem_wdata=0x12345678; next cycle empty=1.
- dm word at 0x20 = 0xAABBCCDD; buffered store be=4'b0010 data 0x0000EE00 -> drain mem_wdata=0xAABBEEDD.
- Stores to 0x30 of 0x11111111 (be F) then 0x00002200 (be 0010), load 0x30 held each cycle before drain -> ld_data=0x11112211, ld_stall=0.
- Fill DEPTH=4 entries while ld_valid held high -> st_ready=0, ld_stall=1, one drain occurs (count 4->3), next cycle ld_stall=0.
- flush=1 with 3 pending and a concurrent st_valid -> store not accepted, empty=1 after 3 drain cycles.
- Assert reset with 2 entries pending mid-drain -> mem_we=0 immediately, empty=1, no further dm writes; with STORE_BUF_TRACE_EN, the trace line count equals the drain count.

Source files
------------

// File: rtl/dm_store_buffer.sv
// ============================================================================
// Module   : dm_store_buffer
// Purpose  : Byte-enabled store FIFO that drains into dm by read-merge-write
//            and forwards buffered bytes into CPU load results.
// Options  : STORE_BUF_TRACE_EN - simulation-only trace of every drain write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [31:0]   st_addr,
   input  logic [31:0]   st_data,
   input  logic [3:0]    st_be,
   input  logic [31:0]   st_pc,
   input  logic          ld_valid,
   input  logic [31:0]   ld_addr,
   output logic [31:0]   ld_data,
   output logic          ld_stall,
   input  logic          flush,
   output logic          empty,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   mem_pc,
   output logic [31:0]   mem_full_addr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0] valid_q;
   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [3:0]       be_q   [DEPTH];
   logic [31:0]      pc_q   [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q, count_d;

   logic        w_full;
   logic        w_enq;
   logic        w_drain;
   logic        w_ld_own;
   logic [31:0] w_head_addr;
   logic [31:0] w_head_data;
   logic [3:0]  w_head_be;
   logic [31:0] w_fwd;

   // Only the dm word-address bits of the byte addresses matter here.
   logic w_unused_bits;
   assign w_unused_bits = ^{st_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

   assign w_full      = (count_q == CNT_W'(DEPTH));
   assign st_ready    = !w_full && !flush;
   assign w_enq       = st_valid && st_ready;
   assign w_ld_own    = ld_valid && !w_full;
   assign ld_stall    = ld_valid && w_full;
   assign w_drain     = ld_stall || (!ld_valid && (count_q != '0));
   assign empty       = (count_q == '0);

   assign w_head_addr = addr_q[head_q];
   assign w_head_data = data_q[head_q];
   assign w_head_be   = be_q[head_q];

   assign mem_we        = w_drain;
   assign mem_pc        = pc_q[head_q];
   assign mem_full_addr = {w_head_addr[31:2], 2'b00};

   always_comb begin
      mem_addr = '0;
      if (w_ld_own) begin
         mem_addr = ld_addr[AW+1:2];
      end else if (w_drain) begin
         mem_addr = w_head_addr[AW+1:2];
      end
   end

   for (genvar b = 0; b < 4; b++) begin : g_lane
      assign mem_wdata[8*b +: 8] = w_head_be[b] ? w_head_data[8*b +: 8]
                                                : mem_rdata[8*b +: 8];
   end

   // Walk from head (oldest) to youngest so later stores win per byte.
   always_comb begin
      w_fwd = mem_rdata;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid_q[head_q + PTR_W'(k)] &&
             (addr_q[head_q + PTR_W'(k)][AW+1:2] == ld_addr[AW+1:2])) begin
            for (int b = 0; b < 4; b++) begin
               if (be_q[head_q + PTR_W'(k)][b]) begin
                  w_fwd[8*b +: 8] = data_q[head_q + PTR_W'(k)][8*b +: 8];
               end
            end
         end
      end
   end

   assign ld_data = w_fwd;

   always_comb begin
      count_d = count_q;
      unique case ({w_enq, w_drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (w_enq) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         if (w_drain) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   // Payload needs no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         addr_q[tail_q] <= {st_addr[31:2], 2'b00};
         data_q[tail_q] <= st_data;
         be_q[tail_q]   <= st_be;
         pc_q[tail_q]   <= st_pc;
      end
   end

`ifdef STORE_BUF_TRACE_EN
   always @(posedge clk) begin
      if (!reset && w_drain) begin
         $display("@%h: *%h <= %h", mem_pc, mem_full_addr, mem_wdata);
      end
   end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
// ============================================================================
// Module   : tb_dm_store_buffer
// Purpose  : Directed scoreboard bench for dm_store_buffer with a dm model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          st_valid, st_ready;
   logic [31:0]   st_addr, st_data, st_pc;
   logic [3:0]    st_be;
   logic          ld_valid, ld_stall;
   logic [31:0]   ld_addr, ld_data;
   logic          flush, empty;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata, mem_pc, mem_full_addr;

   logic [31:0] mem [0:(1<<AW)-1];

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [31:0]   pc;
      logic [31:0]   fa;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .st_valid     (st_valid),
      .st_ready     (st_ready),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_be        (st_be),
      .st_pc        (st_pc),
      .ld_valid     (ld_valid),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .ld_stall     (ld_stall),
      .flush        (flush),
      .empty        (empty),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_pc       (mem_pc),
      .mem_full_addr(mem_full_addr)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: every dm write must match the oldest expected drain.
   always @(negedge clk) begin
      exp_t e;
      if (mem_we) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_unexpected: got write %h <= %h, required no write",
                     mem_addr, mem_wdata);
         end else begin
            e = expq.pop_front();
            chk("drain_addr",  32'(mem_addr), 32'(e.a));
            chk("drain_wdata", mem_wdata, e.d);
            chk("drain_pc",    mem_pc, e.pc);
            chk("drain_faddr", mem_full_addr, e.fa);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [31:0] pc, input logic [31:0] fa);
      exp_t e;
      e.a = a; e.d = d; e.pc = pc; e.fa = fa;
      expq.push_back(e);
   endtask

   task automatic st_drive(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] pc);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_be    = be;
      st_pc    = pc;
   endtask

   task automatic st_end;
      @(posedge clk);
      #1;
      st_valid = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] pc);
      st_drive(a, d, be, pc);
      st_end();
   endtask

   initial begin
      st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; st_pc = 0;
      ld_valid = 0; ld_addr = 0; flush = 0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
      mem[0]  = 32'hCAFEF00D;
      mem[8]  = 32'hAABBCCDD;
      mem[16] = 32'h5555AAAA;

      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_st_ready", 32'(st_ready), 32'd1);
      chk("rst_empty",    32'(empty),    32'd1);
      chk("rst_mem_we",   32'(mem_we),   32'd0);
      chk("rst_ld_stall", 32'(ld_stall), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_ld_data",  ld_data,       32'hCAFEF00D);
      step();

      // Full-word store drains on the following cycle
      push_exp(12'h004, 32'h12345678, 32'h100, 32'h10);
      do_store(32'h10, 32'h12345678, 4'hF, 32'h100);
      @(negedge clk);
      chk("t1_empty_draining", 32'(empty), 32'd0);
      step();
      @(negedge clk);
      chk("t1_empty_after", 32'(empty), 32'd1);
      step();

      // Partial store merges with existing dm word
      push_exp(12'h008, 32'hAABBEEDD, 32'h104, 32'h20);
      do_store(32'h22, 32'h0000EE00, 4'b0010, 32'h104);
      repeat (2) step();
      chk("t2_dm_merged", mem[8], 32'hAABBEEDD);

      // Forwarding: youngest wins per byte; same-cycle store not forwarded
      ld_valid = 1'b1;
      ld_addr  = 32'h30;
      push_exp(12'h00C, 32'h11111111, 32'h108, 32'h30);
      push_exp(12'h00C, 32'h11112211, 32'h10C, 32'h30);
      do_store(32'h30, 32'h11111111, 4'hF, 32'h108);
      st_drive(32'h30, 32'h00002200, 4'b0010, 32'h10C);
      @(negedge clk);
      chk("t3_ld_same_cycle", ld_data, 32'h11111111);
      st_end();
      @(negedge clk);
      chk("t3_ld_fwd",   ld_data,       32'h11112211);
      chk("t3_ld_stall", 32'(ld_stall), 32'd0);
      chk("t3_mem_we",   32'(mem_we),   32'd0);
      chk("t3_mem_addr", 32'(mem_addr), 32'h00C);
      step();
      ld_valid = 1'b0;
      repeat (3) step();
      chk("t3_empty", 32'(empty), 32'd1);

      // Full buffer with load pending: one forced drain, then load proceeds
      ld_valid = 1'b1;
      ld_addr  = 32'h40;
      push_exp(12'h014, 32'hA0A0A0A0, 32'h200, 32'h50);
      push_exp(12'h015, 32'hA1A1A1A1, 32'h204, 32'h54);
      push_exp(12'h016, 32'hA2A2A2A2, 32'h208, 32'h58);
      push_exp(12'h017, 32'hA3A3A3A3, 32'h20C, 32'h5C);
      do_store(32'h50, 32'hA0A0A0A0, 4'hF, 32'h200);
      do_store(32'h54, 32'hA1A1A1A1, 4'hF, 32'h204);
      do_store(32'h58, 32'hA2A2A2A2, 4'hF, 32'h208);
      do_store(32'h5C, 32'hA3A3A3A3, 4'hF, 32'h20C);
      @(negedge clk);
      chk("t4_full_st_ready", 32'(st_ready), 32'd0);
      chk("t4_full_ld_stall", 32'(ld_stall), 32'd1);
      chk("t4_full_mem_we",   32'(mem_we),   32'd1);
      step();
      @(negedge clk);
      chk("t4_after_ld_stall", 32'(ld_stall), 32'd0);
      chk("t4_after_st_ready", 32'(st_ready), 32'd1);
      chk("t4_after_mem_we",   32'(mem_we),   32'd0);
      chk("t4_after_ld_data",  ld_data,       32'h5555AAAA);
      step();
      ld_valid = 1'b0;
      repeat (4) step();
      chk("t4_empty", 32'(empty), 32'd1);

      // Flush blocks a concurrent store while three entries drain
      ld_valid = 1'b1;
      ld_addr  = 32'h0;
      push_exp(12'h018, 32'hB0B0B0B0, 32'h300, 32'h60);
      push_exp(12'h019, 32'hB1B1B1B1, 32'h304, 32'h64);
      push_exp(12'h01A, 32'hB2B2B2B2, 32'h308, 32'h68);
      do_store(32'h60, 32'hB0B0B0B0, 4'hF, 32'h300);
      do_store(32'h64, 32'hB1B1B1B1, 4'hF, 32'h304);
      do_store(32'h68, 32'hB2B2B2B2, 4'hF, 32'h308);
      ld_valid = 1'b0;
      flush    = 1'b1;
      st_drive(32'h6C, 32'hDEADBEEF, 4'hF, 32'h30C);
      @(negedge clk);
      chk("t5_flush_st_ready", 32'(st_ready), 32'd0);
      chk("t5_flush_empty0",   32'(empty),    32'd0);
      step();
      step();
      @(negedge clk);
      chk("t5_flush_empty1", 32'(empty), 32'd0);
      step();
      @(negedge clk);
      chk("t5_flush_empty", 32'(empty), 32'd1);
      step();
      st_valid = 1'b0;
      flush    = 1'b0;
      repeat (2) step();

      // Reset while the second of two entries is draining
      ld_valid = 1'b1;
      ld_addr  = 32'h0;
      push_exp(12'h01C, 32'h77777777, 32'h400, 32'h70);
      do_store(32'h70, 32'h77777777, 4'hF, 32'h400);
      do_store(32'h74, 32'h88888888, 4'hF, 32'h404);
      ld_valid = 1'b0;
      step();
      chk("t6_we_before_reset", 32'(mem_we), 32'd1);
      reset = 1'b1;
      #1;
      chk("t6_rst_mem_we",   32'(mem_we),   32'd0);
      chk("t6_rst_empty",    32'(empty),    32'd1);
      chk("t6_rst_st_ready", 32'(st_ready), 32'd1);
      repeat (3) step();
      reset = 1'b0;
      repeat (3) step();
      chk("t6_dm_untouched", mem[12'h01D], 32'h0);
      chk("t6_dm_first",     mem[12'h01C], 32'h77777777);

      chk("scoreboard_left", 32'(expq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
